// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter that time-shares one overlapping serial pattern detector among N_REQ
// requesters, shifting each granted word MSB-first and reporting its match count.
module seq_det_arbiter #(
    parameter int unsigned      N_REQ   = 4,
    parameter int unsigned      WORD_W  = 16,
    parameter int unsigned      PAT_W   = 6,
    parameter logic [PAT_W-1:0] PATTERN = 6'b110101,
    parameter int unsigned      MCNT_W  = $clog2(WORD_W + 1),
    localparam int unsigned     ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WORD_W-1:0]   data_in,
    output logic [N_REQ-1:0]          gnt,
    output logic                      busy,
    output logic                      d_serial,
    output logic                      done,
    output logic [ID_W-1:0]           done_id,
    output logic [MCNT_W-1:0]         match_cnt,
    output logic                      match_any
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ID_W-1:0]     done_id_q, done_id_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [MCNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [MCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [PAT_W-1:0]    window_q, window_d;
    logic [FILL_W-1:0]   win_fill_q, win_fill_d;

    logic                win_found;
    logic [ID_W-1:0]     win_idx;
    logic [ID_W-1:0]     cand;
    logic                last_bit;

    assign last_bit = (bit_cnt_q == MCNT_W'(WORD_W - 1));

    // Circular search for the first requester at or after rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ID_W'((32'(rr_ptr_q) + i) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            rr_ptr_q    <= '0;
            match_cnt_q <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            window_q    <= '0;
            win_fill_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            rr_ptr_q    <= rr_ptr_d;
            match_cnt_q <= match_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            window_q    <= window_d;
            win_fill_q  <= win_fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (win_found) state_d = StShift;
            StShift: if (last_bit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt_d       = gnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        rr_ptr_d    = rr_ptr_q;
        match_cnt_d = match_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        window_d    = window_q;
        win_fill_d  = win_fill_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    busy_d         = 1'b1;
                    shreg_d        = data_in[win_idx*WORD_W +: WORD_W];
                    done_id_d      = win_idx;
                    match_cnt_d    = '0;
                    bit_cnt_d      = '0;
                    window_d       = '0;
                    win_fill_d     = '0;
                    rr_ptr_d       = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + ID_W'(1);
                end
            end
            StShift: begin
                window_d   = {window_q[PAT_W-2:0], shreg_q[WORD_W-1]};
                shreg_d    = {shreg_q[WORD_W-2:0], 1'b0};
                bit_cnt_d  = bit_cnt_q + MCNT_W'(1);
                win_fill_d = (win_fill_q == FILL_W'(PAT_W)) ? win_fill_q
                                                            : win_fill_q + FILL_W'(1);
                // A match needs a fully populated window so leading zeros never alias.
                if (window_d == PATTERN && win_fill_d == FILL_W'(PAT_W)) begin
                    match_cnt_d = match_cnt_q + MCNT_W'(1);
                end
                if (last_bit) done_d = 1'b1;
            end
            StDone: begin
                gnt_d  = '0;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        d_serial  = (state_q == StShift) ? shreg_q[WORD_W-1] : 1'b0;
        match_any = |match_cnt_q;
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Randomized self-checking bench for seq_det_arbiter against a word-level reference model.
module tb_seq_det_arbiter;

    localparam int NR = 4;
    localparam int WW = 16;
    localparam int PW = 6;
    localparam logic [PW-1:0] PAT = 6'b110101;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [NR-1:0]  req;
    logic [NR*WW-1:0] data_in;
    logic [NR-1:0]  gnt;
    logic           busy, d_serial, done, match_any;
    logic [1:0]     done_id;
    logic [4:0]     match_cnt;

    int n_checks = 0;
    int n_fails  = 0;
    int ptr      = 0;
    int cycle    = 0;

    seq_det_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .data_in   (data_in),
        .gnt       (gnt),
        .busy      (busy),
        .d_serial  (d_serial),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt),
        .match_any (match_any)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int i = 0; i < NR; i++) begin
            if (r[(p + i) % NR]) return (p + i) % NR;
        end
        return -1;
    endfunction

    // Count every (possibly overlapping) occurrence of PAT read MSB-first.
    function automatic int count_matches(input logic [WW-1:0] w);
        int c = 0;
        for (int i = 0; i <= WW - PW; i++) begin
            if (w[WW-1-i -: PW] == PAT) c++;
        end
        return c;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_dser"}, 32'(d_serial), 0);
        check({tag, "_id"}, 32'(done_id), 0);
        check({tag, "_mcnt"}, 32'(match_cnt), 0);
        check({tag, "_many"}, 32'(match_any), 0);
    endtask

    // Called in an IDLE cycle; the next edge grants. Returns winner and DONE cycle number.
    task automatic run_word(input logic [NR-1:0] r, input bit jitter, input bit hold_req,
                            output int w, output int done_cyc);
        logic [WW-1:0] wd;
        int exp_m;
        req   = r;
        w     = pick(r, ptr);
        wd    = data_in[w*WW +: WW];
        exp_m = count_matches(wd);
        ptr   = (w + 1) % NR;
        for (int k = 1; k <= WW; k++) begin
            tick;
            check("gnt", 32'(gnt), 32'(1) << w);
            check("d_serial", 32'(d_serial), 32'(wd[WW-k]));
            if (k == 1) begin
                check("busy", 32'(busy), 1);
                check("done_id_grant", 32'(done_id), 32'(w));
            end
            if (k == WW) check("no_early_done", 32'(done), 0);
            if (jitter) begin
                req     = NR'($urandom);
                data_in = {$urandom, $urandom};
            end
        end
        tick;
        done_cyc = cycle;
        check("done", 32'(done), 1);
        check("done_id", 32'(done_id), 32'(w));
        check("match_cnt", 32'(match_cnt), 32'(exp_m));
        check("match_any", 32'(match_any), 32'(exp_m != 0));
        check("gnt_done", 32'(gnt), 32'(1) << w);
        check("dser_done", 32'(d_serial), 0);
        req = hold_req ? r : '0;
        tick;
        check("done_pulse", 32'(done), 0);
        check("gnt_idle", 32'(gnt), 0);
        check("busy_idle", 32'(busy), 0);
        check("mcnt_held", 32'(match_cnt), 32'(exp_m));
        check("id_held", 32'(done_id), 32'(w));
    endtask

    initial begin
        int w, dc, prev_dc;
        int exp_order[5] = '{0, 1, 2, 3, 0};

        // Reset with random inputs.
        reset_n = 1'b0;
        req     = NR'($urandom);
        data_in = {$urandom, $urandom};
        tick;
        tick;
        check_all_zero("reset");
        reset_n = 1'b1;
        req     = '0;
        tick;
        check_all_zero("idle_after_reset");

        // Fairness with all requesting, back-to-back words.
        prev_dc = 0;
        for (int i = 0; i < 5; i++) begin
            data_in = {$urandom, $urandom};
            run_word(4'b1111, 1'b0, 1'b1, w, dc);
            check("rr_order", 32'(w), 32'(exp_order[i]));
            if (i > 0) check("done_period", 32'(dc - prev_dc), 18);
            prev_dc = dc;
        end
        data_in = {$urandom, $urandom};
        run_word(4'b0101, 1'b0, 1'b1, w, dc);
        check("rr_0101_a", 32'(w), 2);
        run_word(4'b0101, 1'b0, 1'b0, w, dc);
        check("rr_0101_b", 32'(w), 0);

        // Three overlapping matches.
        data_in[0*WW +: WW] = 16'hD6B5;
        run_word(4'b0001, 1'b0, 1'b0, w, dc);
        check("d6b5_cnt", 32'(match_cnt), 3);

        // No-match words.
        data_in[2*WW +: WW] = 16'h0000;
        run_word(4'b0100, 1'b0, 1'b0, w, dc);
        data_in[2*WW +: WW] = 16'hFFFF;
        run_word(4'b0100, 1'b0, 1'b0, w, dc);

        // No match across word boundaries.
        data_in[1*WW +: WW] = 16'h001A;
        run_word(4'b0010, 1'b0, 1'b0, w, dc);
        data_in[2*WW +: WW] = 16'h8000;
        run_word(4'b0100, 1'b0, 1'b0, w, dc);

        // Reset in the 5th SHIFT cycle of a transfer.
        data_in[0*WW +: WW] = 16'hD6B5;
        req = 4'b0001;
        tick;
        for (int k = 0; k < 4; k++) begin
            check("mid_no_done", 32'(done), 0);
            tick;
        end
        reset_n = 1'b0;
        req     = '0;
        tick;
        check_all_zero("mid_reset");
        ptr     = 0;
        reset_n = 1'b1;
        data_in = {$urandom, $urandom};
        run_word(4'b1000, 1'b0, 1'b0, w, dc);
        check("post_reset_winner", 32'(w), 3);

        // Randomized traffic with req/data wiggling mid-word.
        for (int i = 0; i < 40; i++) begin
            data_in = {$urandom, $urandom};
            if (i % 4 == 0) data_in[($urandom % NR)*WW +: WW] = 16'hD6B5;
            run_word(NR'($urandom_range(1, 15)), 1'b1, 1'b0, w, dc);
        end

        req = '0;
        tick;
        check("final_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/seq_det_arbiter.md
# seq_det_arbiter

Round-robin scheduler that shares one serial pattern detector among `N_REQ` requesters. Each requester presents a parallel word. The block grants one requester at a time, latches its word and shifts it MSB-first through an internal overlapping sequence detector (default pattern `110101`). It then reports the number of matches found in that word. It sits between the word-level requesters and the bit-serial sequence-detector datapath, and replaces ad-hoc per-requester detector instances.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters.
- `WORD_W`, 16: bits per word; must be at least `PAT_W`.
- `PAT_W`, 6: pattern length; must be at least 2.
- `PATTERN`, 6'b110101: pattern to detect. The leftmost bit is the first bit received.
- `MCNT_W`, `$clog2(WORD_W+1)`: match counter width.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `req` input `N_REQ`: request bits, one per requester; level-sensitive.
- `data_in` input `N_REQ*WORD_W`: word for requester i at `[i*WORD_W +: WORD_W]`.
- `gnt` output `N_REQ`: one-hot grant.
- `busy` output 1: high in SHIFT and DONE.
- `d_serial` output 1: bit currently applied to the detector.
- `done` output 1: one-cycle pulse when a word completes.
- `done_id` output `$clog2(N_REQ)`: index of the requester whose word completed.
- `match_cnt` output `MCNT_W`: number of matches in the completed word.
- `match_any` output 1: equals `match_cnt != 0`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - On an edge with `req != 0`, select the first set `req` bit at or after `rr_ptr`, searching circularly.
  - Set `gnt` one-hot for that requester.
  - Latch its word into `shreg`.
  - Set `done_id` to the winner's index.
  - Clear `match_cnt`, `bit_cnt`, `window` and `win_fill`.
  - Set `rr_ptr` to winner+1 modulo `N_REQ`.
  - Go to SHIFT.
- **SHIFT**
  - `d_serial = shreg[WORD_W-1]`.
  - Each edge:
    - `window <= {window[PAT_W-2:0], d_serial}`.
    - `shreg` shifts left by one, filling with 0.
    - `bit_cnt` increments.
    - `win_fill` increments, saturating at `PAT_W`.
    - If the new window equals `PATTERN` and the new `win_fill` equals `PAT_W`, `match_cnt` increments.
  - Matches may overlap.
  - On the edge where `bit_cnt == WORD_W-1`, go to DONE.
- **DONE**
  - `done` = 1 for exactly this one cycle; `gnt` stays asserted.
  - Next edge: clear `gnt` and go to IDLE.
- **Detector state between words**: `window` and `win_fill` are cleared at every grant. No match ever spans two words.
- **Sampling**
  - `data_in` is sampled only on the grant edge.
  - `req` is ignored outside IDLE. Dropping `req` mid-word does not abort the word.
  - A requester still holding `req` in IDLE competes normally; its round-robin priority is lowest.
- **Held outputs**: `match_cnt`, `match_any` and `done_id` hold their values after DONE until the next grant.
- **Outputs outside SHIFT**: `d_serial` = 0 in IDLE and DONE.
- **Reset** (`reset_n` = 0 at an edge, any state, including mid-SHIFT):
  - State goes to IDLE.
  - `gnt`, `busy`, `done`, `d_serial`, `done_id`, `match_cnt`, `match_any` are all 0.
  - `rr_ptr`, `shreg`, `bit_cnt`, `window` and `win_fill` are 0.
  - A partial word is discarded; no `done` is issued for it.

## Timing
- Edge E0, in IDLE with `req` set: the grant is registered. `gnt` and `busy` are high in the cycle after E0.
- SHIFT occupies cycles E0+1 through E0+`WORD_W`. The bit applied in cycle E0+k is word bit `[WORD_W-k]`.
- DONE is cycle E0+`WORD_W`+1. `match_cnt` and `match_any` are final in this cycle and remain stable.
- IDLE follows at E0+`WORD_W`+2. The earliest next grant is the edge ending that IDLE cycle.
- Throughput is one word per `WORD_W`+2 cycles, which is 18 at the defaults.
- All outputs are registered except `d_serial` and `match_any`, which decode registers only.

## Test plan
- **Reset values**: hold `reset_n` = 0 for 2 edges with random `req` and `data_in` -> every output is 0 and state is IDLE.
- **Single requester, three overlapping matches**: `req[0]` = 1, word0 = 16'hD6B5 -> `gnt` = 4'b0001 for 17 cycles; `d_serial` sequence is 1101011010110101; `done` pulses 17 cycles after grant with `done_id` = 0, `match_cnt` = 3, `match_any` = 1.
- **No matches**: `req[2]` = 1 with word 16'h0000, then with 16'hFFFF -> each completes with `done_id` = 2, `match_cnt` = 0, `match_any` = 0.
- **Round-robin fairness**: `req` = 4'b1111 held continuously -> grant order 0,1,2,3,0; `done` pulses every 18 cycles.
  - Then `req` = 4'b0101 after a grant to 0 -> next grant is 2, then 0.
- **No cross-word match**: requester 1 word 16'h001A (ends in 11010) is granted, followed by requester 2 word 16'h8000 -> both complete with `match_cnt` = 0.
- **Reset mid-word**: assert `reset_n` = 0 at the 5th SHIFT cycle of a 16'hD6B5 transfer -> no `done`; all outputs are 0 next cycle.
  - On release with `req[3]` = 1, requester 3 is granted first, because `rr_ptr` resets to 0 and only requester 3 is requesting.
